rca_accumulator: RTL
====================

// Module: rca_accumulator
// PURPOSE
//  Streaming accumulator stage downstream of the ripple-carry adder: sums a packet of unsigned
//  BITWIDTH-bit operands (e.g. approximate partial products) into an ACC_WIDTH-bit register.
//  Each accepted beat drives the adder with (acc, zero-extended operand, cin=0); the carry-out is
//  the overflow source. Completed sums are held on a valid/ready output until consumed.
// PARAMETERS
//  BITWIDTH   8   width of each input operand (unsigned)
//  ACC_WIDTH  20  accumulator/result width; must be > BITWIDTH
//  CNT_WIDTH  8   width of beat counter; packets longer than 2**CNT_WIDTH-1 beats saturate the count
//  SATURATE   0   0: result wraps mod 2**ACC_WIDTH; 1: result clamps to all-ones on overflow
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          synchronous reset, active-high
//  in_valid     in   1          operand beat present
//  in_ready     out  1          stage can accept a beat this cycle
//  in_data      in   BITWIDTH   operand
//  in_last      in   1          beat is the final operand of the packet
//  out_valid    out  1          packet result held
//  out_ready    in   1          consumer accepts result
//  out_data     out  ACC_WIDTH  accumulated sum
//  out_count    out  CNT_WIDTH  number of beats in the packet
//  out_overflow out  1          sticky: at least one carry-out occurred during the packet
// BEHAVIOUR
//  - Reset: state=ACCUM, acc=0, count=0, ovf=0; out_valid=0, out_data=0, out_count=0, out_overflow=0,
//    in_ready=1 in the cycle after rst deasserts. Reset mid-packet or mid-hold discards all state.
//  - States: ACCUM (in_ready=1, out_valid=0), HOLD (in_ready=0, out_valid=1).
//  - ACCUM, beat accepted (in_valid&in_ready): sum = acc + {0,in_data} (ACC_WIDTH+1 bits).
//    carry=sum[ACC_WIDTH]. acc <= SATURATE&(carry|ovf) ? all-ones : sum[ACC_WIDTH-1:0];
//    ovf <= ovf|carry; count <= count+1, holding at all-ones (no wrap).
//  - ACCUM, accepted beat with in_last=1: same update, then state->HOLD next cycle; out_data,
//    out_count, out_overflow present the updated acc/count/ovf. Latency: last beat to out_valid = 1 cycle.
//  - ACCUM, in_valid=0: no change. in_data/in_last ignored when not accepted.
//  - HOLD: outputs stable while out_ready=0. On out_valid&out_ready: acc, count, ovf cleared,
//    state->ACCUM; in_ready=1 in the following cycle (no same-cycle bypass; throughput
//    is one packet per N+1 cycles for N beats).
//  - Single-beat packet (in_last on first beat) is legal: out_data=in_data, out_count=1.
//  - out_data/out_count/out_overflow are registered; values outside HOLD are don't-care but
//    must be 0 after reset.
//  - SATURATE=1: once clamped, acc stays all-ones for the rest of the packet.
// TESTING
//  1. Reset, then beats 3,5,7 (last on 7), out_ready=1 -> out_valid 1 cycle after last, out_data=15,
//     out_count=3, out_overflow=0; in_ready back to 1 the cycle after handshake.
//  2. Backpressure: packet {10,20} then out_ready=0 for 5 cycles -> in_ready=0, out_data=30 stable
//     throughout; result released and acc cleared when out_ready=1.
//  3. Overflow, ACC_WIDTH=9, BITWIDTH=8: beats 255,255,255 -> SATURATE=0: out_data=765 mod 512=253,
//     out_overflow=1; SATURATE=1: out_data=511, out_overflow=1.
//  4. Gaps: beats 1,(in_valid=0 x3),2,(gap),4 last -> out_data=7, out_count=3.
//  5. rst asserted after 2 beats of a packet -> all outputs 0; next packet {9} last -> out_data=9,
//     out_count=1, out_overflow=0.
//  6. Back-to-back packets {1,1} and {2}: second packet's sum is 2, not 4 (acc cleared on handshake).

Source files
------------

// File: rtl/rca_accumulator_if.sv
// rca_accumulator_if
//   Bundles the operand stream (in_*) and the result stream (out_*) of the
//   rca_accumulator stage.
//   Handshake: a beat or result moves on a rising clk edge where valid and
//   ready are both 1. The producer keeps valid and its payload steady until
//   that edge. The consumer may change ready freely. valid never depends
//   combinationally on ready.
//   Modports:
//     slave  - the accumulator (consumes in_*, produces out_*)
//     master - the environment (produces in_*, consumes out_*)
interface rca_accumulator_if #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BITWIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_overflow;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_overflow
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_overflow
  );
endinterface

// File: rtl/rca_accumulator.sv
// rca_accumulator
//   Streaming accumulator behind a ripple-carry adder. It sums a packet of
//   unsigned BITWIDTH-bit operands into an ACC_WIDTH-bit register. The packet
//   ends on the beat that has in_last set. The completed sum, the beat count
//   and a sticky overflow flag are then held on the out_* stream until the
//   consumer accepts them.
//   Ports:
//     clk       - clock; all state changes on the rising edge
//     rst       - synchronous reset, active-high
//     bus       - rca_accumulator_if.slave (in_* operand stream, out_* result)
//     dbg_state - current FSM state (0 = ACCUM, 1 = HOLD)
//   Parameters:
//     BITWIDTH  - operand width. ACC_WIDTH must be larger than BITWIDTH.
//     ACC_WIDTH - accumulator and result width
//     CNT_WIDTH - beat counter width. The counter saturates at all-ones.
//     SATURATE  - 0: the sum wraps; 1: the sum clamps to all-ones on overflow
module rca_accumulator #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 8,
  parameter int SATURATE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  rca_accumulator_if.slave    bus,
  output logic [0:0]          dbg_state
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] count;
  logic                 ovf;

  logic                 accept;
  logic [ACC_WIDTH-1:0] op_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 rc;

  assign accept = (state == ST_ACCUM) && bus.in_valid;

  // Ripple-carry adder: acc + zero-extended operand, with carry-in 0.
  // The final carry becomes sum[ACC_WIDTH] and is the overflow source.
  always_comb begin
    op_ext = '0;
    op_ext[BITWIDTH-1:0] = bus.in_data;
    sum = '0;
    rc  = 1'b0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      sum[i] = acc[i] ^ op_ext[i] ^ rc;
      rc     = (acc[i] & op_ext[i]) | (rc & (acc[i] ^ op_ext[i]));
    end
    sum[ACC_WIDTH] = rc;
  end

  assign carry = sum[ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            // The sticky ovf term keeps a clamped sum at all-ones for the
            // rest of the packet, even when later beats do not carry.
            if ((SATURATE != 0) && (carry || ovf)) begin
              acc <= '1;
            end else begin
              acc <= sum[ACC_WIDTH-1:0];
            end
            ovf <= ovf | carry;
            if (count != '1) begin
              count <= count + 1'b1;
            end
            if (bus.in_last) begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // No bypass: the next packet starts one cycle after the handshake.
          if (bus.out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= ST_ACCUM;
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

  // The result registers are the accumulator registers themselves. In HOLD
  // they carry the completed packet. In ACCUM they show the running partial,
  // which the consumer ignores because out_valid is 0.
  assign bus.in_ready     = (state == ST_ACCUM);
  assign bus.out_valid    = (state == ST_HOLD);
  assign bus.out_data     = acc;
  assign bus.out_count    = count;
  assign bus.out_overflow = ovf;
  assign dbg_state        = state;

endmodule
